// File: rtl/risc16_pkg.sv
// Shared definitions for the risc16 memory path: requester ids, RAM read/write encoding
// and the default address/data widths used by mem_arb and its interface.
package risc16_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_rw_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the core requesters plus RAM (master side) and the arbiter (slave side).
interface mem_arb_if #(
    parameter int AW = risc16_pkg::DEF_AW,
    parameter int DW = risc16_pkg::DEF_DW
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          ram_en;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_rw, ram_addr, ram_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_rw, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_arb_sel.sv
// Combinational grant picker for mem_arb; returns a one-hot grant indexed by req_id_t.
// MEM_ARB_RR_EN selects round-robin on contention, otherwise data always beats fetch.
module mem_arb_sel
    import risc16_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  req_id_t    ptr,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        // NOTE: gnt gets a default before any branch so no path leaves it unassigned and infers a latch.
        gnt = 2'b00;
        if (if_req && d_req) begin
            gnt[ptr] = 1'b1;
        end else if (d_req) begin
            gnt[REQ_D] = 1'b1;
        end else if (if_req) begin
            gnt[REQ_IF] = 1'b1;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        gnt = 2'b00;
        if (d_req) begin
            gnt[REQ_D] = 1'b1;
        end else if (if_req) begin
            gnt[REQ_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store, routing
// each read response back to its owner one cycle after grant. Optional macro: MEM_ARB_RR_EN.
module mem_arb
    import risc16_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    logic [1:0]    sel_gnt;
    logic [1:0]    gnt;
    logic          if_gnt;
    logic          d_gnt;
    logic          rd_gnt;
    req_id_t       ptr;
    logic          resp_v;
    req_id_t       resp_owner;
    logic          if_rvalid;
    logic          d_rvalid;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    mem_arb_sel u_sel (
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .ptr    (ptr),
        .gnt    (sel_gnt)
    );

    // Grants are masked while reset is held so nothing reaches the RAM.
    assign gnt    = rst ? sel_gnt : 2'b00;
    assign if_gnt = gnt[REQ_IF];
    assign d_gnt  = gnt[REQ_D];
    assign rd_gnt = if_gnt | (d_gnt & ~bus.d_we);

`ifdef MEM_ARB_RR_EN
    // ptr names the requester favoured on the next contention; every grant hands it to the other side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= REQ_IF;
        end else if (d_gnt) begin
            ptr <= REQ_IF;
        end else if (if_gnt) begin
            ptr <= REQ_D;
        end
    end
`else
    assign ptr = REQ_IF;
`endif

    // Stores need no response; only read grants arm the one-cycle return slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state flops update with <= so every flop samples pre-edge values.
            resp_v     <= 1'b0;
            resp_owner <= REQ_IF;
        end else begin
            resp_v <= rd_gnt;
            if (rd_gnt) begin
                resp_owner <= d_gnt ? REQ_D : REQ_IF;
            end
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (d_gnt) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
        end else if (if_gnt) begin
            addr_mux  = bus.if_addr;
        end
    end

    assign if_rvalid = resp_v && (resp_owner == REQ_IF);
    assign d_rvalid  = resp_v && (resp_owner == REQ_D);

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.ram_rdata : '0;
    assign bus.d_rdata   = d_rvalid  ? bus.ram_rdata : '0;

    assign bus.ram_en    = if_gnt | d_gnt;
    assign bus.ram_rw    = (d_gnt && bus.d_we) ? MEM_WR : MEM_RD;
    assign bus.ram_addr  = addr_mux;
    assign bus.ram_wdata = wdata_mux;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: a behavioural RAM behind the arbiter and a per-requester read scoreboard.
// Define MEM_ARB_RR_EN for both RTL and bench to exercise the round-robin contention case.
`timescale 1ns/1ps
module tb_mem_arb;
    import risc16_pkg::*;

    localparam int LIMIT = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_if[$];
    logic [15:0] exp_d[$];

    // RAM model (driven by the DUT's RAM port) and a separate reference image kept by the monitor.
    bit          ram_wr[256];
    logic [15:0] ram_val[256];
    logic [15:0] rdata_q = '0;
    bit          ref_wr[256];
    logic [15:0] ref_val[256];

    function automatic logic [15:0] preload(input logic [15:0] a);
        return (a == 16'h001F) ? 16'd10 : (a ^ 16'hA5C3);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_wr[a[7:0]] ? ref_val[a[7:0]] : preload(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.ram_en === 1'b1) begin
            if (bus.ram_rw) begin
                ram_wr[bus.ram_addr[7:0]]  <= 1'b1;
                ram_val[bus.ram_addr[7:0]] <= bus.ram_wdata;
            end else begin
                rdata_q <= ram_wr[bus.ram_addr[7:0]] ? ram_val[bus.ram_addr[7:0]] : preload(bus.ram_addr);
            end
        end
    end
    assign bus.ram_rdata = rdata_q;

    // Monitor: pop/compare responses first, then push expectations for this cycle's grants.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.if_rvalid) begin
                if (exp_if.size() == 0) check("if_rvalid_unexpected", bus.if_rvalid, 0);
                else                    check("if_rdata", bus.if_rdata, exp_if.pop_front());
                check("d_rdata_nonowner", bus.d_rdata, 0);
            end
            if (bus.d_rvalid) begin
                if (exp_d.size() == 0) check("d_rvalid_unexpected", bus.d_rvalid, 0);
                else                   check("d_rdata", bus.d_rdata, exp_d.pop_front());
                check("if_rdata_nonowner", bus.if_rdata, 0);
            end
            if (rst && bus.if_req && bus.d_req)
                check("gnt_onehot", 32'(bus.if_gnt) + 32'(bus.d_gnt), 1);
            if (bus.if_gnt) exp_if.push_back(ref_read(bus.if_addr));
            if (bus.d_gnt) begin
                if (bus.d_we) begin
                    ref_wr[bus.d_addr[7:0]]  = 1'b1;
                    ref_val[bus.d_addr[7:0]] = bus.d_wdata;
                end else begin
                    exp_d.push_back(ref_read(bus.d_addr));
                end
            end
        end
    end

    task automatic fetch(input logic [15:0] a, output int waited);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        waited      = 0;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (bus.if_gnt) break;
            waited++;
        end
        check("if_gnt_seen", bus.if_gnt, 1);
        check("if_ram_addr", bus.ram_addr, a);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [15:0] a, input logic [15:0] wd, output int waited);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        waited      = 0;
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (bus.d_gnt) break;
            waited++;
        end
        check("d_gnt_seen", bus.d_gnt, 1);
        check("d_ram_rw", bus.ram_rw, we);
        check("d_ram_addr", bus.ram_addr, a);
        if (we) check("d_ram_wdata", bus.ram_wdata, wd);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, w_if0, w_if1, w_d0, w_d1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset: requests held high must not produce grants or RAM activity.
        repeat (2) @(posedge clk);
        #1;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        @(negedge clk);
        check("rst_if_gnt", bus.if_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_if_rvalid", bus.if_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Fetch-only streaming, granted every cycle from the first cycle after reset.
        for (int i = 0; i < 6; i++) begin
            fetch(16'h000F + 16'(i), w);
            check("stream_wait", w, 0);
        end
        repeat (2) @(posedge clk);
        #1;

        // Contention: data load wins, fetch follows one cycle later.
        fork
            fetch(16'h0030, w_if0);
            data(1'b0, 16'h001F, 16'h0000, w_d0);
        join
        check("cont_d_wait", w_d0, 0);
        check("cont_if_wait", w_if0, 1);
        repeat (2) @(posedge clk);
        #1;

        // Store then load of the same address on consecutive grants.
        data(1'b1, 16'h0020, 16'hBEEF, w);
        check("st_wait", w, 0);
        data(1'b0, 16'h0020, 16'h0000, w);
        check("ld_wait", w, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the cycle after a fetch grant discards the in-flight response.
        fetch(16'h0040, w);
        rst = 1'b0;
        exp_if.delete();
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0041;
        repeat (2) begin
            @(negedge clk);
            check("rstmid_if_rvalid", bus.if_rvalid, 0);
            check("rstmid_if_gnt", bus.if_gnt, 0);
            check("rstmid_ram_en", bus.ram_en, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        fetch(16'h0041, w);
        check("post_rst_wait", w, 0);
        repeat (2) @(posedge clk);

        // Sustained contention from a fresh reset: two requests per side.
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        fork
            begin
                fetch(16'h0050, w_if0);
                fetch(16'h0051, w_if1);
            end
            begin
                data(1'b0, 16'h0060, 16'h0000, w_d0);
                data(1'b0, 16'h0061, 16'h0000, w_d1);
            end
        join
`ifdef MEM_ARB_RR_EN
        check("rr_if0_wait", w_if0, 0);
        check("rr_d0_wait", w_d0, 1);
        check("rr_if1_wait", w_if1, 1);
        check("rr_d1_wait", w_d1, 1);
`else
        check("fp_d0_wait", w_d0, 0);
        check("fp_d1_wait", w_d1, 0);
        check("fp_if0_wait", w_if0, 2);
        check("fp_if1_wait", w_if1, 0);
`endif

        repeat (3) @(posedge clk);
        check("if_queue_drained", exp_if.size(), 0);
        check("d_queue_drained", exp_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter that shares the single-port synchronous RAM between the instruction-fetch path and the load/store data path of the risc16 core. It grants at most one RAM access per cycle, drives the RAM address/control/write-data, and routes each read response back to its owner one cycle later with a valid strobe. It sits between the core's control/PC logic and the `ram` instance, replacing direct PC and `mem_addr` wiring.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `if_req`  input  1  fetch request, read-only
- `if_addr`  input  AW  fetch address (PC)
- `if_gnt`  output  1  fetch granted this cycle
- `if_rvalid`  output  1  `if_rdata` valid
- `if_rdata`  output  DW  fetched instruction
- `d_req`  input  1  data request
- `d_we`  input  1  1 = store, 0 = load
- `d_addr`  input  AW  data address
- `d_wdata`  input  DW  store data
- `d_gnt`  output  1  data access granted this cycle
- `d_rvalid`  output  1  `d_rdata` valid (loads only)
- `d_rdata`  output  DW  load data
- `ram_en`  output  1  RAM access this cycle
- `ram_rw`  output  1  1 = write, 0 = read
- `ram_addr`  output  AW  RAM address
- `ram_wdata`  output  DW  RAM write data
- `ram_rdata`  input  DW  RAM read data, valid one cycle after a read is issued

## Operation
- Requester raises `req` with stable addr/data, then holds them until it sees `gnt` high at a rising edge. `req` may drop only after grant.
- `gnt` is combinational from `req` and arbitration state. At most one of `if_gnt`/`d_gnt` is high per cycle. `ram_en` = `if_gnt | d_gnt`.
- RAM signals are muxed from the granted requester. `ram_rw` = `d_gnt & d_we`. When idle, addr/wdata are 0.
- Priority (default): data wins over fetch, so loads/stores stall fetch.
- Response tracking registers `resp_v` and `resp_owner` are loaded on each read grant. The next cycle asserts the owner's `rvalid` for exactly one cycle, with `rdata` = `ram_rdata`.
- Non-owner `rdata` is 0.
- Stores produce no `rvalid`. A store is complete at its grant edge.
- Fully pipelined: a new grant may coincide with an outstanding response. Throughput is one access per cycle.
- Write-then-read to the same address on consecutive grants returns the new data.

## Timing
- Reset (`rst`=0) values: `if_rvalid`=`d_rvalid`=0, `resp_v`=0, RR pointer = fetch, all `rdata` outputs 0.
- While `rst`=0, both `gnt` outputs and `ram_en` are forced 0.
- Grant latency is 0 cycles when uncontended. Read latency is grant + 1 cycle.
- Reset asserted with a read in flight: the response is discarded and no `rvalid` follows after release.
- First grant is possible in the first cycle after `rst` deasserts.
- Simultaneous `if_req` and `d_req`: exactly one grant. The loser holds its request and is re-evaluated next cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit pointer records the last granted requester and updates on every grant. On contention, the other requester wins, so neither waits more than 1 cycle.
- `MEM_ARB_RR_EN` undefined: fixed data-over-fetch priority. No pointer flop exists.

## Structure
- `risc16_pkg` holds:
  - requester id constants `REQ_IF`=0 and `REQ_D`=1
  - RAM rw encoding constants `MEM_RD`=0 and `MEM_WR`=1
  - the default `AW`/`DW` values
- Sub-module `mem_arb_sel` is the combinational picker. Inputs: both reqs and the pointer. Outputs: one-hot grant. The macro is confined to this sub-module and the pointer flop.

## Test plan
- Fetch-only streaming: `if_req` held with addr 0x000F..0x0014 -> grant every cycle, `if_rvalid` every cycle from cycle 2, and `if_rdata` matches RAM preload in order.
- Contention, fixed priority: both request, load 0x001F = 10 -> `d_gnt` first, `d_rvalid` next cycle with `d_rdata` = 10, and `if_gnt` one cycle later.
- Contention with `MEM_ARB_RR_EN`: both held for 4 cycles -> grants alternate IF, D, IF, D starting from fetch after reset.
- Store then load: store 0x0020 = 0xBEEF, then load 0x0020 -> `ram_rw`=1 for one cycle, no `d_rvalid` for the store, and the load returns 0xBEEF.
- Reset mid-read: `rst` low in the cycle after a fetch grant -> `if_rvalid` stays 0 and no grants while low. After release, the first request is granted immediately.
